// File: rtl/flash_phy_pkg.sv
// Shared types for the flash PHY read path: read-buffer entry layout and
// the read-buffer controller state encoding.
package flash_phy_pkg;

  localparam int BankAddrW      = 8;
  localparam int PlainDataWidth = 16;
  localparam int InfoTypesWidth = 2;

  typedef enum logic [1:0] {
    Invalid = 2'd0,
    Wip     = 2'd1,
    Valid   = 2'd2
  } rd_buf_attr_e;

  typedef struct packed {
    rd_buf_attr_e              attr;
    logic [BankAddrW-1:0]      addr;
    logic                      part;
    logic [InfoTypesWidth-1:0] info_sel;
    logic [PlainDataWidth-1:0] data;
    logic                      err;
  } rd_buf_t;

  // Address tag only; what lookups compare against
  typedef struct packed {
    logic [BankAddrW-1:0]      addr;
    logic                      part;
    logic [InfoTypesWidth-1:0] info_sel;
  } rd_tag_t;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StFlashReq = 2'd1,
    StDataWait = 2'd2,
    StResp     = 2'd3
  } rd_ctrl_state_e;

endpackage

// File: rtl/flash_phy_rd_buf_lookup.sv
// Combinational tag lookup across all read buffers: hit, in-progress match,
// program-wipe candidates and replacement victim.
module flash_phy_rd_buf_lookup import flash_phy_pkg::*; #(
  parameter int NumBuf = 4,
  parameter int IdxW   = $clog2(NumBuf)
) (
  input  rd_buf_attr_e [NumBuf-1:0] attr,
  input  rd_tag_t      [NumBuf-1:0] tag,
  input  logic         [NumBuf-1:0] err,
  input  rd_tag_t                   req_tag,
  input  rd_tag_t                   prog_tag,
  input  logic         [IdxW-1:0]   rr_ptr,
  output logic                      hit,
  output logic         [IdxW-1:0]   hit_idx,
  output logic                      wip_match,
  output logic         [NumBuf-1:0] wipe_vec,
  output logic         [IdxW-1:0]   victim
);

  logic [NumBuf-1:0] valid_match;
  logic [NumBuf-1:0] wip_vec;
  logic [NumBuf-1:0] inv_vec;
  logic [NumBuf-1:0] err_vec;

  for (genvar gi = 0; gi < NumBuf; gi++) begin : g_cmp
    logic req_eq;
    assign req_eq          = (tag[gi] == req_tag);
    assign valid_match[gi] = (attr[gi] == Valid) && !err[gi] && req_eq;
    assign wip_vec[gi]     = (attr[gi] == Wip) && req_eq;
    assign wipe_vec[gi]    = (attr[gi] != Invalid) && (tag[gi] == prog_tag);
    assign inv_vec[gi]     = (attr[gi] == Invalid);
    assign err_vec[gi]     = (attr[gi] == Valid) && err[gi];
  end

  assign hit       = |valid_match;
  assign wip_match = |wip_vec;

  // Descending scans so the lowest set index is the one left standing
  always_comb begin
    hit_idx = '0;
    for (int i = NumBuf - 1; i >= 0; i--) begin
      if (valid_match[i]) hit_idx = IdxW'(i);
    end
  end

  // Invalid entries beat errored ones, which beat round-robin
  always_comb begin
    victim = rr_ptr;
    for (int i = NumBuf - 1; i >= 0; i--) begin
      if (err_vec[i]) victim = IdxW'(i);
    end
    for (int i = NumBuf - 1; i >= 0; i--) begin
      if (inv_vec[i]) victim = IdxW'(i);
    end
  end

endmodule

// File: rtl/flash_phy_rd_buf_ctrl.sv
// Read-buffer controller: serves hits from the buffers, allocates and fills a
// victim on a miss with one outstanding flash read, and wipes programmed tags.
module flash_phy_rd_buf_ctrl import flash_phy_pkg::*; #(
  parameter int NumBuf   = 4,
  parameter int AddrW    = BankAddrW,
  parameter int DataW    = PlainDataWidth,
  parameter int InfoSelW = InfoTypesWidth
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       req_i,
  input  logic [AddrW-1:0]           req_addr_i,
  input  logic                       req_part_i,
  input  logic [InfoSelW-1:0]        req_info_sel_i,
  output logic                       req_ready_o,
  input  logic                       prog_i,
  input  logic [AddrW-1:0]           prog_addr_i,
  input  logic                       prog_part_i,
  input  logic [InfoSelW-1:0]        prog_info_sel_i,
  input  rd_buf_t [NumBuf-1:0]       buf_i,
  output logic [NumBuf-1:0]          alloc_o,
  output logic [NumBuf-1:0]          update_o,
  output logic [NumBuf-1:0]          wipe_o,
  output logic                       flash_req_o,
  output logic [AddrW-1:0]           flash_addr_o,
  output logic                       flash_part_o,
  output logic [InfoSelW-1:0]        flash_info_sel_o,
  input  logic                       flash_ack_i,
  input  logic                       flash_done_i,
  input  logic [DataW-1:0]           flash_data_i,
  input  logic                       flash_err_i,
  output logic                       rsp_valid_o,
  output logic [DataW-1:0]           rsp_data_o,
  output logic                       rsp_err_o,
  output logic                       rsp_hit_o
);

  localparam int IdxW = $clog2(NumBuf);

  rd_ctrl_state_e            state;
  logic [IdxW-1:0]           rr_ptr;
  logic [IdxW-1:0]           victim_q;
  logic                      bypass;
  logic                      wiped_flag;

  rd_buf_attr_e [NumBuf-1:0] attr;
  rd_tag_t      [NumBuf-1:0] tag;
  logic         [NumBuf-1:0] err;
  logic                      hit;
  logic         [IdxW-1:0]   hit_idx;
  logic                      wip_match;
  logic         [NumBuf-1:0] wipe_vec;
  logic         [IdxW-1:0]   victim;
  logic         [IdxW-1:0]   rr_next;
  logic                      inflight_wipe;

  for (genvar gi = 0; gi < NumBuf; gi++) begin : g_split
    assign attr[gi] = buf_i[gi].attr;
    assign tag[gi]  = '{addr: buf_i[gi].addr, part: buf_i[gi].part,
                        info_sel: buf_i[gi].info_sel};
    assign err[gi]  = buf_i[gi].err;
  end

  flash_phy_rd_buf_lookup #(.NumBuf(NumBuf), .IdxW(IdxW)) u_lookup (
    .attr      (attr),
    .tag       (tag),
    .err       (err),
    .req_tag   ('{addr: req_addr_i, part: req_part_i, info_sel: req_info_sel_i}),
    .prog_tag  ('{addr: prog_addr_i, part: prog_part_i, info_sel: prog_info_sel_i}),
    .rr_ptr    (rr_ptr),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .wip_match (wip_match),
    .wipe_vec  (wipe_vec),
    .victim    (victim)
  );

  // Programs win over reads; a read to an in-progress tag waits for its fill
  assign req_ready_o   = (state == StIdle) && req_i && !prog_i &&
                         (!en_i || hit || !wip_match);
  assign wipe_o        = prog_i ? wipe_vec : '0;
  assign inflight_wipe = prog_i && wipe_vec[victim_q] && !bypass;
  assign rr_next       = (victim == IdxW'(NumBuf - 1)) ? '0 : victim + 1'b1;

  always_comb begin
    alloc_o = '0;
    if (req_ready_o && en_i && !hit) alloc_o[victim] = 1'b1;
  end

  // Only fill an entry still waiting for this read, i.e. not wiped or disabled
  always_comb begin
    update_o = '0;
    if (state == StDataWait && flash_done_i && !bypass && en_i && !wiped_flag &&
        !inflight_wipe && attr[victim_q] == Wip) begin
      update_o[victim_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= StIdle;
      rr_ptr           <= '0;
      victim_q         <= '0;
      bypass           <= 1'b0;
      wiped_flag       <= 1'b0;
      flash_req_o      <= 1'b0;
      flash_addr_o     <= '0;
      flash_part_o     <= 1'b0;
      flash_info_sel_o <= '0;
      rsp_valid_o      <= 1'b0;
      rsp_data_o       <= '0;
      rsp_err_o        <= 1'b0;
      rsp_hit_o        <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        StIdle: begin
          if (req_ready_o) begin
            if (en_i && hit) begin
              rsp_valid_o <= 1'b1;
              rsp_data_o  <= buf_i[hit_idx].data;
              rsp_err_o   <= 1'b0;
              rsp_hit_o   <= 1'b1;
            end else begin
              flash_addr_o     <= req_addr_i;
              flash_part_o     <= req_part_i;
              flash_info_sel_o <= req_info_sel_i;
              flash_req_o      <= 1'b1;
              bypass           <= !en_i;
              wiped_flag       <= 1'b0;
              state            <= StFlashReq;
              if (en_i) begin
                victim_q <= victim;
                rr_ptr   <= rr_next;
              end
            end
          end
        end
        StFlashReq: begin
          if (inflight_wipe) wiped_flag <= 1'b1;
          if (flash_ack_i) begin
            flash_req_o <= 1'b0;
            state       <= StDataWait;
          end
        end
        StDataWait: begin
          if (inflight_wipe) wiped_flag <= 1'b1;
          if (flash_done_i) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= flash_data_i;
            rsp_err_o   <= flash_err_i;
            rsp_hit_o   <= 1'b0;
            state       <= StResp;
          end
        end
        default: begin
          wiped_flag <= 1'b0;
          state      <= StIdle;
        end
      endcase
    end
  end

endmodule
